// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: arbitration modes, default geometry and the built-in CHIP-8 font image.
package mem_arbiter_pkg;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_e;

    localparam int unsigned DEF_ADDR_WIDTH  = 12;
    localparam int unsigned DEF_DATA_WIDTH  = 8;
    localparam int unsigned DEF_MEMORY_SIZE = 4096;
    localparam int unsigned DEF_FONT_BASE   = 'h14;
    localparam int unsigned DEF_FONT_END    = 'h99;
    localparam int unsigned FONT_BYTES      = 80;

    // Hex digits 0..F, five rows each; locations past the table up to FONT_END preload as zero.
    localparam logic [7:0] FONT_ROM [FONT_BYTES] = '{
        8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0,  8'h20, 8'h60, 8'h20, 8'h20, 8'h70,
        8'hF0, 8'h10, 8'hF0, 8'h80, 8'hF0,  8'hF0, 8'h10, 8'hF0, 8'h10, 8'hF0,
        8'h90, 8'h90, 8'hF0, 8'h10, 8'h10,  8'hF0, 8'h80, 8'hF0, 8'h10, 8'hF0,
        8'hF0, 8'h80, 8'hF0, 8'h90, 8'hF0,  8'hF0, 8'h10, 8'h20, 8'h40, 8'h40,
        8'hF0, 8'h90, 8'hF0, 8'h90, 8'hF0,  8'hF0, 8'h90, 8'hF0, 8'h10, 8'hF0,
        8'hF0, 8'h90, 8'hF0, 8'h90, 8'h90,  8'hE0, 8'h90, 8'hE0, 8'h90, 8'hE0,
        8'hF0, 8'h80, 8'h80, 8'h80, 8'hF0,  8'hE0, 8'h90, 8'h90, 8'h90, 8'hE0,
        8'hF0, 8'h80, 8'hF0, 8'h80, 8'hF0,  8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80
    };

    function automatic logic [7:0] font_byte(input int unsigned i);
        logic [7:0] b;
        b = '0;
        if (i < FONT_BYTES) b = FONT_ROM[7'(i)];
        return b;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_arbiter.sv
// rr_arbiter: combinational grant selection, fixed-priority or round-robin from a caller-held pointer.
module rr_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned  NUM_PORTS = 3,
    parameter arb_mode_e    MODE      = ARB_RR,
    localparam int unsigned PW        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic [NUM_PORTS-1:0] i_eligible,
    input  logic [PW-1:0]        i_ptr,
    output logic [NUM_PORTS-1:0] o_grant,
    output logic [PW-1:0]        o_grant_idx,
    output logic                 o_grant_valid
);

    logic [PW-1:0] w_j;

    // Scan in priority order; the first eligible port seen wins.
    always_comb begin
        o_grant       = '0;
        o_grant_idx   = '0;
        o_grant_valid = 1'b0;
        w_j           = '0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            if (MODE == ARB_FIXED) w_j = PW'(k);
            else                   w_j = PW'((32'(i_ptr) + 1 + k) % NUM_PORTS);
            if (!o_grant_valid && i_eligible[w_j]) begin
                o_grant[w_j]  = 1'b1;
                o_grant_idx   = w_j;
                o_grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shared CHIP-8 memory with N arbitrated read/write ports, one access per cycle,
// plus an independent read-only scan port. Font glyphs are preloaded and survive reset.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned NUM_PORTS   = 3,
    parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int unsigned MEMORY_SIZE = DEF_MEMORY_SIZE,
    parameter arb_mode_e   ARB_MODE    = ARB_RR,
    parameter int unsigned FONT_BASE   = DEF_FONT_BASE,
    parameter int unsigned FONT_END    = DEF_FONT_END
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_PORTS-1:0]            req,
    input  logic [NUM_PORTS-1:0]            we,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] wdata,
    output logic [NUM_PORTS*DATA_WIDTH-1:0] rdata,
    output logic [NUM_PORTS-1:0]            ack,
    input  logic                            scan_read,
    input  logic [ADDR_WIDTH-1:0]           scan_addr,
    output logic [DATA_WIDTH-1:0]           scan_data
);

    localparam int unsigned PW    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int unsigned IDX_W = (MEMORY_SIZE > 1) ? $clog2(MEMORY_SIZE) : 1;

    function automatic logic [MEMORY_SIZE-1:0][DATA_WIDTH-1:0] font_image();
        logic [MEMORY_SIZE-1:0][DATA_WIDTH-1:0] img;
        img = '0;
        for (int unsigned a = FONT_BASE; a <= FONT_END; a++)
            if (a < MEMORY_SIZE) img[IDX_W'(a)] = DATA_WIDTH'(font_byte(a - FONT_BASE));
        return img;
    endfunction

    logic [MEMORY_SIZE-1:0][DATA_WIDTH-1:0] r_mem = font_image();

    logic [PW-1:0]                 r_ptr;
    logic [NUM_PORTS-1:0]          r_ack;
    logic [NUM_PORTS*DATA_WIDTH-1:0] r_rdata;
    logic [DATA_WIDTH-1:0]         r_scan_data;

    logic [NUM_PORTS-1:0]  w_eligible;
    logic [NUM_PORTS-1:0]  w_grant;
    logic [PW-1:0]         w_gidx;
    logic                  w_grant_valid;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic                  w_we;
    logic                  w_in_range;
    logic [IDX_W-1:0]      w_idx;
    logic                  w_scan_in_range;
    logic [IDX_W-1:0]      w_scan_idx;

    // A port is masked during its own ack cycle so a held request cannot issue twice.
    assign w_eligible = req & ~r_ack;

    rr_arbiter #(
        .NUM_PORTS (NUM_PORTS),
        .MODE      (ARB_MODE)
    ) u_arb (
        .i_eligible    (w_eligible),
        .i_ptr         (r_ptr),
        .o_grant       (w_grant),
        .o_grant_idx   (w_gidx),
        .o_grant_valid (w_grant_valid)
    );

    always_comb begin
        w_addr  = '0;
        w_wdata = '0;
        w_we    = 1'b0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (w_grant[i]) begin
                w_addr  = addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_wdata = wdata[i*DATA_WIDTH +: DATA_WIDTH];
                w_we    = we[i];
            end
        end
    end

    assign w_in_range      = 32'(w_addr) < MEMORY_SIZE;
    assign w_idx           = w_addr[IDX_W-1:0];
    assign w_scan_in_range = 32'(scan_addr) < MEMORY_SIZE;
    assign w_scan_idx      = scan_addr[IDX_W-1:0];

    // Memory contents are never reset; a grant landing on the reset edge is simply discarded.
    always_ff @(posedge clk) begin
        if (!reset && w_grant_valid && w_we && w_in_range)
            r_mem[w_idx] <= w_wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ack       <= '0;
            r_rdata     <= '0;
            r_scan_data <= '0;
            r_ptr       <= PW'(NUM_PORTS - 1);
        end else begin
            r_ack <= w_grant;
            if (w_grant_valid) begin
                r_ptr <= w_gidx;
                if (!w_we) begin
                    for (int unsigned i = 0; i < NUM_PORTS; i++)
                        if (w_grant[i])
                            r_rdata[i*DATA_WIDTH +: DATA_WIDTH] <= w_in_range ? r_mem[w_idx] : '0;
                end
            end
            if (scan_read)
                r_scan_data <= w_scan_in_range ? r_mem[w_scan_idx] : '0;
        end
    end

    assign ack       = r_ack;
    assign rdata     = r_rdata;
    assign scan_data = r_scan_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of a round-robin instance, with a fixed-priority twin on the same stimulus.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  req, we, ack, fix_ack;
    logic [11:0] p_addr  [3];
    logic [7:0]  p_wdata [3];
    logic [35:0] addr;
    logic [23:0] wdata, rdata, fix_rdata;
    logic        scan_read;
    logic [11:0] scan_addr;
    logic [7:0]  scan_data, fix_scan_data;

    int n_checks = 0;
    int n_err    = 0;

    assign addr  = {p_addr[2], p_addr[1], p_addr[0]};
    assign wdata = {p_wdata[2], p_wdata[1], p_wdata[0]};

    always #5 clk = ~clk;

    mem_arbiter #(
        .NUM_PORTS   (3),
        .ADDR_WIDTH  (12),
        .DATA_WIDTH  (8),
        .MEMORY_SIZE (2048),
        .ARB_MODE    (ARB_RR)
    ) u_rr (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .ack       (ack),
        .scan_read (scan_read),
        .scan_addr (scan_addr),
        .scan_data (scan_data)
    );

    mem_arbiter #(
        .NUM_PORTS   (3),
        .ADDR_WIDTH  (12),
        .DATA_WIDTH  (8),
        .MEMORY_SIZE (2048),
        .ARB_MODE    (ARB_FIXED)
    ) u_fix (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (fix_rdata),
        .ack       (fix_ack),
        .scan_read (scan_read),
        .scan_addr (scan_addr),
        .scan_data (fix_scan_data)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
        end
    endtask

    // One idle edge, then a single-port access; ack is checked and req dropped in the ack cycle.
    task automatic do_op(input logic [1:0] p, input logic w, input logic [11:0] a, input logic [7:0] d);
        tick();
        req[p]     = 1'b1;
        we[p]      = w;
        p_addr[p]  = a;
        p_wdata[p] = d;
        tick();
        check("op_ack", 32'(ack), 32'(1) << p);
        req[p] = 1'b0;
    endtask

    initial begin
        req       = '0;
        we        = '0;
        p_addr    = '{default: '0};
        p_wdata   = '{default: '0};
        scan_read = 1'b0;
        scan_addr = '0;
        tick();
        tick();
        reset = 1'b0;

        check("rst_ack",   32'(ack),       0);
        check("rst_rdata", 32'(rdata),     0);
        check("rst_scan",  32'(scan_data), 0);
        check("rst_fack",  32'(fix_ack),   0);

        do_op(0, 1'b0, 12'h014, 8'h00);
        check("font_0", 32'(rdata[7:0]), 'hF0);
        do_op(0, 1'b0, 12'h019, 8'h00);
        check("font_5", 32'(rdata[7:0]), 'h20);

        // Port 1 write and port 0 read of the same word requested together.
        tick();
        req        = 3'b011;
        we         = 3'b010;
        p_addr[0]  = 12'h200;
        p_addr[1]  = 12'h200;
        p_wdata[1] = 8'hA5;
        tick();
        check("wr_ack1", 32'(ack), 2);
        req[1] = 1'b0;
        tick();
        check("rd_ack0", 32'(ack), 1);
        check("rd_after_wr", 32'(rdata[7:0]), 'hA5);
        req[0] = 1'b0;

        reset = 1'b1;
        tick();
        reset = 1'b0;
        we     = '0;
        p_addr = '{12'h014, 12'h019, 12'h015};
        req    = 3'b111;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("rr_grant",  32'(ack),     1 << (k % 3));
            check("fix_grant", 32'(fix_ack), 1 << (k % 2));
        end
        req = '0;
        tick();
        check("rr_idle",   32'(ack),       0);
        check("fix_idle",  32'(fix_ack),   0);
        check("rr_rdata",  32'(rdata),     'h9020F0);
        check("fix_starve", 32'(fix_rdata), 'h0020F0);

        do_op(0, 1'b1, 12'h300, 8'h22);
        tick();
        req[0]     = 1'b1;
        we[0]      = 1'b1;
        p_addr[0]  = 12'h300;
        p_wdata[0] = 8'h11;
        scan_read  = 1'b1;
        scan_addr  = 12'h300;
        tick();
        check("coll_ack",  32'(ack),           1);
        check("scan_old",  32'(scan_data),     'h22);
        check("fscan_old", 32'(fix_scan_data), 'h22);
        req[0] = 1'b0;
        tick();
        check("scan_new", 32'(scan_data), 'h11);
        scan_read = 1'b0;
        tick();
        check("scan_hold", 32'(scan_data), 'h11);
        scan_read = 1'b1;
        scan_addr = 12'h900;
        tick();
        check("scan_oor", 32'(scan_data), 0);
        scan_read = 1'b0;

        do_op(0, 1'b1, 12'h100, 8'h3C);
        do_op(2, 1'b1, 12'h900, 8'h77);
        check("oor_wr_rdata", 32'(rdata[23:16]), 'h90);
        do_op(2, 1'b0, 12'h900, 8'h00);
        check("oor_rd_zero", 32'(rdata[23:16]), 0);
        do_op(0, 1'b0, 12'h100, 8'h00);
        check("oor_no_alias", 32'(rdata[7:0]), 'h3C);

        // Pointer now sits on port 1; a write is held across the reset edge.
        do_op(1, 1'b1, 12'h400, 8'h33);
        tick();
        reset      = 1'b1;
        req[1]     = 1'b1;
        we[1]      = 1'b1;
        p_addr[1]  = 12'h400;
        p_wdata[1] = 8'h55;
        tick();
        reset = 1'b0;
        req   = '0;
        check("rst_mid_ack",   32'(ack),   0);
        check("rst_mid_rdata", 32'(rdata), 0);
        we     = '0;
        p_addr = '{12'h014, 12'h019, 12'h015};
        req    = 3'b111;
        tick();
        check("rst_ptr", 32'(ack), 1);
        req = '0;
        do_op(1, 1'b0, 12'h400, 8'h00);
        check("rst_no_write", 32'(rdata[15:8]), 'h33);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
